// File: rtl/lsu_req_if.sv
// Request/response handshake bundle between the core memory stage and the
// LSU request controller.
interface lsu_req_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [1:0]            rsp_cause;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );

    // Controller side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );
endinterface

// File: rtl/lsu_req_ctrl.sv
// Request-side controller for the LSU: decodes funct3, faults bad accesses,
// drives one LSU access per request and returns a single response.
module lsu_req_ctrl #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDRESS_SPACE  = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          NUM_DATA_TYPES = 6,
    localparam int         ADDR_W         = $clog2(ADDRESS_SPACE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lsu_req_if.slave              bus,
    output logic [ADDR_W-1:0]     lsu_addr_o,
    output logic [DATA_WIDTH-1:0] lsu_data_o,
    output logic                  lsu_we_o,
    output logic [2:0]            lsu_dtype_o,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    // The LSU disables all byte banks for this dtype code.
    localparam logic [2:0] DTYPE_NOP = 3'b111;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
    localparam logic [1:0] CAUSE_RANGE     = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd3;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic [2:0]            dtype_dec;
    logic                  illegal;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fault;
    logic [1:0]            cause_dec;
    logic                  below_base;
    logic [31:0]           off;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic [1:0]            rsp_cause_q;
    logic [ADDR_W-1:0]     lsu_addr_q;
    logic [DATA_WIDTH-1:0] lsu_data_q;
    logic                  lsu_we_q;
    logic [2:0]            lsu_dtype_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Decode funct3 into an LSU dtype and classify the request's fault, if any.
    always_comb begin
        dtype_dec = DTYPE_NOP;
        illegal   = 1'b0;
        case (bus.req_funct3)
            3'b000: dtype_dec = 3'd0;
            3'b001: dtype_dec = 3'd1;
            3'b010: dtype_dec = 3'd2;
            3'b100: begin
                dtype_dec = 3'd3;
                illegal   = bus.req_we;
            end
            3'b101: begin
                dtype_dec = 3'd4;
                illegal   = bus.req_we;
            end
            default: illegal = 1'b1;
        endcase
        // A dtype code the LSU does not implement can never be issued.
        if (int'(dtype_dec) >= NUM_DATA_TYPES) begin
            illegal = 1'b1;
        end

        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

        // The 33-bit difference exposes the borrow, i.e. an address below the base.
        {below_base, off} = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
        out_of_range = below_base || (off >= 32'(ADDRESS_SPACE));

        fault = illegal || misaligned || out_of_range;
        if (illegal) begin
            cause_dec = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            cause_dec = CAUSE_MISALIGN;
        end else if (out_of_range) begin
            cause_dec = CAUSE_RANGE;
        end else begin
            cause_dec = CAUSE_NONE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: faults skip the LSU, stores skip the capture cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fault ? RESP : ACCESS;
                end
            end
            ACCESS:  state_next = lsu_we_q ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // LSU drive and response registers, updated per state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
            lsu_addr_q  <= '0;
            lsu_data_q  <= '0;
            lsu_we_q    <= 1'b0;
            lsu_dtype_q <= DTYPE_NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fault) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_cause_q <= cause_dec;
                        end else begin
                            lsu_addr_q  <= off[ADDR_W-1:0];
                            lsu_dtype_q <= dtype_dec;
                            if (bus.req_we) begin
                                lsu_data_q <= bus.req_wdata;
                                lsu_we_q   <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    lsu_we_q <= 1'b0;
                    if (lsu_we_q) begin
                        // Store done: the write happened at this edge.
                        lsu_dtype_q <= DTYPE_NOP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_cause_q <= CAUSE_NONE;
                    end
                    // Loads keep addr/dtype so the LSU output decode stays valid.
                end
                CAPTURE: begin
                    lsu_dtype_q <= DTYPE_NOP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= lsu_data_i;
                    rsp_err_q   <= 1'b0;
                    rsp_cause_q <= CAUSE_NONE;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) && reset_n;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_cause = rsp_cause_q;

    // Gating with reset_n keeps a store caught by reset from writing at that edge.
    assign lsu_we_o    = lsu_we_q && reset_n;
    assign lsu_addr_o  = lsu_addr_q;
    assign lsu_data_o  = lsu_data_q;
    assign lsu_dtype_o = lsu_dtype_q;
    assign busy        = (state != IDLE);
endmodule
